// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer closing the loop with pc_src_mux: IDLE/RUN/DONE control,
// saturating fetch counter. Optional misaligned-PC fault check enabled by PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned PC_STEP     = 32'd4,
   parameter logic [8:0]  HALT_OPCODE = 9'h1FF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [PC_WIDTH-1:0] start_pc,
   input  logic                stall,
   input  logic [PC_WIDTH-1:0] pc_in,
   input  logic [8:0]          instruction,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                fetch_valid,
   output logic                done,
   output logic                fault,
   output logic [31:0]         instr_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [31:0]         cnt_inc_s;
   logic                fault_q, fault_d;
   logic                is_halt_s;

   assign is_halt_s = (instruction == HALT_OPCODE);
   // The counter sticks at all-ones rather than wrapping back to zero.
   assign cnt_inc_s = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : (cnt_q + 32'd1);

   // State register, PC, counter and fault flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         cnt_q   <= 32'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   // Next-state logic: start, stall, halt and (optionally) alignment fault.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               pc_d    = start_pc;
               cnt_d   = 32'd0;
               fault_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            // Stall beats halt; start is ignored while running.
            if (stall) begin
               state_d = ST_RUN;
            end else if (is_halt_s) begin
               state_d = ST_DONE;
               cnt_d   = cnt_inc_s;
            end else begin
               cnt_d = cnt_inc_s;
`ifdef PC_ALIGN_CHECK_EN
               if (pc_in[1:0] != 2'b00) begin
                  fault_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  pc_d = pc_in;
               end
`else
               pc_d = pc_in;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = '0;
            cnt_d   = 32'd0;
            fault_d = 1'b0;
         end
      endcase
`ifndef PC_ALIGN_CHECK_EN
      fault_d = 1'b0;
`endif
   end

   assign pc          = pc_q;
   assign next_pc     = pc_q + PC_WIDTH'(PC_STEP);
   assign fetch_valid = (state_q == ST_RUN);
   assign done        = (state_q == ST_DONE);
   assign fault       = fault_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed test-plan sequence with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_pc_fetch_unit;

   localparam logic [8:0] HALT = 9'h1FF;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] start_pc;
   logic        stall;
   logic [31:0] pc_in;
   logic [8:0]  instruction;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        fetch_valid;
   logic        done;
   logic        fault;
   logic [31:0] instr_count;

   int checks = 0;
   int errors = 0;

   pc_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_pc    (start_pc),
      .stall       (stall),
      .pc_in       (pc_in),
      .instruction (instruction),
      .pc          (pc),
      .next_pc     (next_pc),
      .fetch_valid (fetch_valid),
      .done        (done),
      .fault       (fault),
      .instr_count (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 = idle, 1 = running, 2 = finished.
   int          m_mode  = 0;
   logic [31:0] m_pc    = 32'd0;
   logic [31:0] m_cnt   = 32'd0;
   logic        m_fault = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  = 0;
         m_pc    = 32'd0;
         m_cnt   = 32'd0;
         m_fault = 1'b0;
      end else begin
         if (m_mode != 1) begin
            if (start) begin
               m_mode  = 1;
               m_pc    = start_pc;
               m_cnt   = 32'd0;
               m_fault = 1'b0;
            end
         end else if (!stall) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (instruction == HALT) begin
               m_mode = 2;
            end
`ifdef PC_ALIGN_CHECK_EN
            else if (pc_in[1:0] != 2'b00) begin
               m_fault = 1'b1;
               m_mode  = 2;
            end
`endif
            else begin
               m_pc = pc_in;
            end
         end
         #1;
         chk("pc", pc, m_pc);
         chk("next_pc", next_pc, m_pc + 32'd4);
         chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_mode == 1});
         chk("done", {31'd0, done}, {31'd0, m_mode == 2});
         chk("fault", {31'd0, fault}, {31'd0, m_fault});
         chk("instr_count", instr_count, m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; start_pc = 32'd0; stall = 1'b0;
      pc_in = 32'd0; instruction = 9'd0;
      #13;
      chk("rst_pc", pc, 32'h0);
      chk("rst_next_pc", next_pc, 32'h4);
      chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cnt", instr_count, 32'd0);
      rst_n = 1'b1;
      tick();

      // Sequential run from 0x40.
      start = 1'b1; start_pc = 32'h40; pc_in = 32'h44;
      tick();
      start = 1'b0;
      chk("start_pc", pc, 32'h40);
      chk("start_fv", {31'd0, fetch_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         pc_in = m_pc + 32'd4;
         tick();
      end
      chk("seq_pc", pc, 32'h4C);
      chk("seq_next_pc", next_pc, 32'h50);
      chk("seq_cnt", instr_count, 32'd3);

      // Halt, then branch from 0x10 to 0x24.
      instruction = HALT;
      tick();
      chk("halt_done", {31'd0, done}, 32'd1);
      instruction = 9'd0; start = 1'b1; start_pc = 32'h10;
      tick();
      start = 1'b0; pc_in = 32'h24;
      tick();
      chk("br_pc", pc, 32'h24);
      chk("br_next_pc", next_pc, 32'h28);

      // Stall with halt present for two cycles, then release.
      stall = 1'b1; instruction = HALT;
      tick();
      tick();
      chk("stall_pc", pc, 32'h24);
      chk("stall_cnt", instr_count, 32'd1);
      chk("stall_fv", {31'd0, fetch_valid}, 32'd1);
      stall = 1'b0;
      tick();
      chk("rel_done", {31'd0, done}, 32'd1);
      chk("rel_pc", pc, 32'h24);
      chk("rel_cnt", instr_count, 32'd2);

      // Restart from DONE, then a start pulse mid-run must be ignored.
      instruction = 9'd0; start = 1'b1; start_pc = 32'h100;
      tick();
      chk("rs_pc", pc, 32'h100);
      chk("rs_cnt", instr_count, 32'd0);
      chk("rs_done", {31'd0, done}, 32'd0);
      start_pc = 32'h200; pc_in = 32'h104;
      tick();
      start = 1'b0;
      chk("ign_pc", pc, 32'h104);

      // Misaligned pc_in.
      pc_in = 32'h22;
      tick();
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_done", {31'd0, done}, 32'd1);
      chk("mis_pc", pc, 32'h104);
      start = 1'b1; start_pc = 32'h300;
      tick();
      start = 1'b0;
      chk("mis_clear", {31'd0, fault}, 32'd0);
`else
      chk("mis_pc", pc, 32'h22);
      chk("mis_fault", {31'd0, fault}, 32'd0);
`endif

      // Halt and start in the same running cycle: halt wins.
      instruction = HALT; start = 1'b1; start_pc = 32'h500;
      tick();
      chk("hs_done", {31'd0, done}, 32'd1);

      // Asynchronous reset mid-run.
      start_pc = 32'h600; instruction = 9'd0; pc_in = 32'h604;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_next_pc", next_pc, 32'h4);
      chk("arst_fv", {31'd0, fetch_valid}, 32'd0);
      chk("arst_fault", {31'd0, fault}, 32'd0);
      chk("arst_cnt", instr_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         start       = ($urandom_range(0, 15) == 0);
         start_pc    = {$urandom_range(0, 32'h3FFF), 2'b00};
         stall       = ($urandom_range(0, 3) == 0);
         instruction = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom_range(0, 9'h1FE));
         case ($urandom_range(0, 7))
            0:       pc_in = $urandom;
            1:       pc_in = 32'hFFFF_FFFC;
            default: pc_in = m_pc + 32'd4;
         endcase
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and fetch sequencer that sits directly downstream of `pc_src_mux` and closes the fetch loop. It holds the architectural PC and drives the instruction-memory address. It produces `next_pc = pc + PC_STEP`, which feeds the mux, and registers the mux's `pc_out` as the next PC. It also runs the start/halt/done handshake with the testbench and top level, and counts fetched instructions.

## Interface
Parameters:
- `PC_WIDTH`, 32, PC and address width
- `PC_STEP`, 4, sequential increment added to `pc` to form `next_pc`
- `HALT_OPCODE`, 9'h1FF, instruction encoding that ends the program

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a program at `start_pc`; honoured only in IDLE or DONE
- `start_pc`  in  PC_WIDTH  first fetch address
- `stall`  in  1  hold PC and counter this cycle
- `pc_in`  in  PC_WIDTH  next PC chosen by `pc_src_mux` (`pc_out`)
- `instruction`  in  9  instruction currently read at `pc`
- `pc`  out  PC_WIDTH  current PC / instruction-memory address
- `next_pc`  out  PC_WIDTH  `pc + PC_STEP`, combinational, modulo 2^PC_WIDTH
- `fetch_valid`  out  1  high when in RUN; `instruction` is meaningful
- `done`  out  1  high when in DONE
- `fault`  out  1  misaligned-PC fault flag (see Configuration)
- `instr_count`  out  32  instructions fetched since last `start`

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start` → RUN; `pc <= start_pc`; `instr_count <= 0`; `fault <= 0`.
- **RUN**
  - `stall=1`: `pc` and `instr_count` hold. The state holds, even if `instruction == HALT_OPCODE`; stall wins over halt.
  - `stall=0`, `instruction == HALT_OPCODE`: → DONE. `pc` holds at the halt address. `instr_count` increments; the halt counts as an instruction.
  - `stall=0`, otherwise: `pc <= pc_in`; `instr_count` increments.
  - `start` in RUN is ignored.
- **DONE**
  - `pc`, `instr_count` and `fault` hold.
  - `start` → RUN with the same actions as from IDLE.
- `instr_count` saturates at 32'hFFFF_FFFF and does not wrap.
- `next_pc` wraps silently modulo 2^PC_WIDTH. `pc_in` is accepted unmodified.
- `done` and `fetch_valid` are decoded from state and are mutually exclusive.

## Timing
- Reset (`rst_n=0`, asynchronous, any state):
  - state IDLE
  - `pc=0`, `next_pc=PC_STEP`
  - `fetch_valid=0`, `done=0`, `fault=0`, `instr_count=0`
- Reset mid-RUN aborts immediately. No partial update survives.
- `start` sampled high at edge N: `pc == start_pc` and `fetch_valid=1` after edge N.
- A RUN cycle with `stall=0` latches `pc_in` at the next edge. The loop latency through the mux is one cycle per instruction.
- `next_pc` follows `pc` combinationally in the same cycle. There is no register between them.
- A halt fetched at edge N-1 (seen during cycle N): `done=1` after edge N. `fetch_valid` drops on the same edge.
- `start` and halt in the same RUN cycle: the halt is taken and `start` is ignored.

## Configuration
- Macro: `PC_ALIGN_CHECK_EN`.
- Defined:
  - In RUN with `stall=0` and no halt, if `pc_in[1:0] != 2'b00`, the PC is not updated. The block sets `fault <= 1` and moves to DONE.
  - `instr_count` still increments for that fetch.
  - `fault` clears on the next accepted `start`.
- Not defined:
  - No alignment check is made; misaligned `pc_in` loads normally.
  - `fault` is tied to 0.

## Test plan
- Reset then `start` with `start_pc=32'h40`, `pc_in = next_pc`, no stall, for 3 cycles → `pc` goes 0x40, 0x44, 0x48, 0x4C. `next_pc` is 0x50 while `pc=0x4C`. `instr_count=3`.
- Branch: while `pc=0x10`, drive `pc_in=0x24` → next cycle `pc=0x24`, `next_pc=0x28`.
- Stall together with `HALT_OPCODE` on `instruction` for 2 cycles, then release stall → `pc` and `instr_count` hold during the stall. `done=1` one edge after release. `pc` is unchanged and `instr_count` is incremented by 1.
- In DONE, pulse `start` with `start_pc=0x100` → RUN, `pc=0x100`, `instr_count=0`, `done=0`. A `start` pulse mid-RUN has no effect.
- Assert `rst_n=0` between edges mid-RUN → all outputs take their reset values immediately, without waiting for a clock edge.
- With `PC_ALIGN_CHECK_EN` defined, drive `pc_in=0x22` → `fault=1`, `done=1`, `pc` unchanged. Without the macro, `pc=0x22` and `fault=0`.
